countdown_timer_ctrl: RTL

Control core of the countdown timer, downstream of the switch debouncers. Consumes their single-cycle KEY_UP pulses (increment, decrement, field select, start/stop) plus a 1 Hz clock-enable tick. Maintains an mm:ss BCD countdown value through a set/run/pause/alarm state machine. Drives the display multiplexer with BCD digits and status flags.

---
 rtl/countdown_timer_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/countdown_timer_ctrl.sv
//------------------------------------------------------------------------------
// countdown_timer_ctrl
//   mm:ss BCD countdown with a set/run/pause/alarm state machine.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module countdown_timer_ctrl #(
   parameter int MAX_MIN     = 99,
   parameter int ALARM_TICKS = 10
) (
   input  logic       CLK,
   input  logic       CLR_N,
   input  logic       TICK,
   input  logic       KEY_INC,
   input  logic       KEY_DEC,
   input  logic       KEY_SEL,
   input  logic       KEY_START,
   output logic [3:0] MIN_T,
   output logic [3:0] MIN_O,
   output logic [3:0] SEC_T,
   output logic [3:0] SEC_O,
   output logic       EDIT_MIN,
   output logic [1:0] STATE,
   output logic       RUNNING,
   output logic       ALARM
);

   typedef enum logic [1:0] {
      ST_SET   = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_ALARM = 2'b11
   } state_t;

   localparam logic [3:0] c_max_t      = 4'(MAX_MIN / 10);
   localparam logic [3:0] c_max_o      = 4'(MAX_MIN % 10);
   localparam logic [7:0] c_alarm_last = 8'(ALARM_TICKS - 1);

   state_t     r_state;
   logic [3:0] r_min_t, r_min_o, r_sec_t, r_sec_o;
   logic       r_edit_min, r_running, r_alarm;
   logic [7:0] r_cnt;

   logic       w_sec_zero, w_min_zero, w_min_max, w_rd_zero, w_any_key;
   logic [3:0] w_si_t, w_si_o, w_sd_t, w_sd_o;
   logic [3:0] w_mi_t, w_mi_o, w_md_t, w_md_o;
   logic [3:0] w_rd_min_t, w_rd_min_o;

   state_t     w_state_nxt;
   logic [3:0] w_min_t_nxt, w_min_o_nxt, w_sec_t_nxt, w_sec_o_nxt;
   logic       w_edit_nxt;
   logic [7:0] w_cnt_nxt;

   // Field-wise BCD +1/-1 with wrap, and the whole-value borrow chain for RUN
   always_comb begin
      w_sec_zero = (r_sec_t == 4'd0) && (r_sec_o == 4'd0);
      w_min_zero = (r_min_t == 4'd0) && (r_min_o == 4'd0);
      w_min_max  = (r_min_t == c_max_t) && (r_min_o == c_max_o);
      w_any_key  = KEY_INC | KEY_DEC | KEY_SEL | KEY_START;

      w_si_t = r_sec_t;
      w_si_o = r_sec_o + 4'd1;
      if (r_sec_o == 4'd9) begin
         w_si_o = 4'd0;
         w_si_t = (r_sec_t == 4'd5) ? 4'd0 : r_sec_t + 4'd1;
      end

      w_sd_t = r_sec_t;
      w_sd_o = r_sec_o - 4'd1;
      if (r_sec_o == 4'd0) begin
         w_sd_o = 4'd9;
         w_sd_t = (r_sec_t == 4'd0) ? 4'd5 : r_sec_t - 4'd1;
      end

      w_mi_t = r_min_t;
      w_mi_o = r_min_o + 4'd1;
      if (w_min_max) begin
         w_mi_t = 4'd0;
         w_mi_o = 4'd0;
      end else if (r_min_o == 4'd9) begin
         w_mi_t = r_min_t + 4'd1;
         w_mi_o = 4'd0;
      end

      w_md_t = r_min_t;
      w_md_o = r_min_o - 4'd1;
      if (w_min_zero) begin
         w_md_t = c_max_t;
         w_md_o = c_max_o;
      end else if (r_min_o == 4'd0) begin
         w_md_t = r_min_t - 4'd1;
         w_md_o = 4'd9;
      end

      w_rd_min_t = w_sec_zero ? w_md_t : r_min_t;
      w_rd_min_o = w_sec_zero ? w_md_o : r_min_o;
      w_rd_zero  = (w_rd_min_t == 4'd0) && (w_rd_min_o == 4'd0) &&
                   (w_sd_t == 4'd0) && (w_sd_o == 4'd0);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_min_t_nxt = r_min_t;
      w_min_o_nxt = r_min_o;
      w_sec_t_nxt = r_sec_t;
      w_sec_o_nxt = r_sec_o;
      w_edit_nxt  = r_edit_min;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_SET: begin
            if (KEY_START) begin
               if (!(w_min_zero && w_sec_zero)) w_state_nxt = ST_RUN;
            end else if (KEY_SEL) begin
               w_edit_nxt = !r_edit_min;
            end else if (KEY_INC) begin
               if (r_edit_min) begin
                  w_min_t_nxt = w_mi_t;
                  w_min_o_nxt = w_mi_o;
               end else begin
                  w_sec_t_nxt = w_si_t;
                  w_sec_o_nxt = w_si_o;
               end
            end else if (KEY_DEC) begin
               if (r_edit_min) begin
                  w_min_t_nxt = w_md_t;
                  w_min_o_nxt = w_md_o;
               end else begin
                  w_sec_t_nxt = w_sd_t;
                  w_sec_o_nxt = w_sd_o;
               end
            end
         end
         ST_RUN: begin
            if (TICK) begin
               w_min_t_nxt = w_rd_min_t;
               w_min_o_nxt = w_rd_min_o;
               w_sec_t_nxt = w_sd_t;
               w_sec_o_nxt = w_sd_o;
            end
            // Reaching 00:00 takes precedence over a simultaneous stop request
            if (TICK && w_rd_zero) begin
               w_state_nxt = ST_ALARM;
               w_cnt_nxt   = 8'd0;
            end else if (KEY_START) begin
               w_state_nxt = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (KEY_START)    w_state_nxt = ST_RUN;
            else if (KEY_SEL) w_state_nxt = ST_SET;
         end
         ST_ALARM: begin
            if (w_any_key) begin
               w_state_nxt = ST_SET;
               w_cnt_nxt   = 8'd0;
            end else if (TICK) begin
               if (r_cnt == c_alarm_last) begin
                  w_state_nxt = ST_SET;
                  w_cnt_nxt   = 8'd0;
               end else begin
                  w_cnt_nxt = r_cnt + 8'd1;
               end
            end
         end
         default: w_state_nxt = ST_SET;
      endcase
   end

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         r_state    <= ST_SET;
         r_min_t    <= 4'd0;
         r_min_o    <= 4'd0;
         r_sec_t    <= 4'd0;
         r_sec_o    <= 4'd0;
         r_edit_min <= 1'b0;
         r_running  <= 1'b0;
         r_alarm    <= 1'b0;
         r_cnt      <= 8'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_min_t    <= w_min_t_nxt;
         r_min_o    <= w_min_o_nxt;
         r_sec_t    <= w_sec_t_nxt;
         r_sec_o    <= w_sec_o_nxt;
         r_edit_min <= w_edit_nxt;
         r_running  <= (w_state_nxt == ST_RUN);
         r_alarm    <= (w_state_nxt == ST_ALARM);
         r_cnt      <= w_cnt_nxt;
      end
   end

   assign MIN_T    = r_min_t;
   assign MIN_O    = r_min_o;
   assign SEC_T    = r_sec_t;
   assign SEC_O    = r_sec_o;
   assign EDIT_MIN = r_edit_min;
   assign STATE    = r_state;
   assign RUNNING  = r_running;
   assign ALARM    = r_alarm;

endmodule

`default_nettype wire
